// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch redirect controller.
package branch_ctrl_pkg;

  localparam int PC_W     = 32;
  localparam int SQ_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } brState_t;

  typedef logic [PC_W-1:0] pc_t;

  // Fetch only handles word-aligned PCs; anything else is a misaligned jump.
  function automatic logic isMisaligned(input pc_t pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/redir_squash_counter.sv
// Loadable down-counter timing the post-redirect refill window; done is combinational on count==1.
// Load takes priority; the count parks at 0 and never backpressures anything.
module redir_squash_counter
  import branch_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SQ_CNT_W-1:0] loadVal,
  output logic                done
);

  logic [SQ_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == SQ_CNT_W'(1));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-branch to fetch redirect sequencer with IF/ID and ID/EX squash; all outputs registered, redirect one cycle after a taken branch.
// Redirect holds valid/PC until fetch ready; optional branch statistics built with BRANCH_STATS_EN.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 1
) (
  input  logic            i_Clk_1,
  input  logic            i_Rst_1,
  input  logic            i_BrValid_1,
  input  logic            i_JumpBranch_1,
  input  logic [PC_W-1:0] i_Target_32,
  input  logic            i_RedirReady_1,
  output logic            o_RedirValid_1,
  output logic [PC_W-1:0] o_RedirPc_32,
  output logic            o_FlushIfId_1,
  output logic            o_FlushIdEx_1,
  output logic            o_Misalign_1,
  output logic [PC_W-1:0] o_MisalignPc_32,
  output logic [31:0]     o_BranchCnt_32,
  output logic [31:0]     o_TakenCnt_32
);

  localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(SQUASH_CYCLES);
  localparam logic                HAS_SQUASH = (SQUASH_CYCLES != 0);

  brState_t state, stateNxt;

  logic brTaken, takenAligned, takenMisaligned;
  logic handshake, sqLoad, sqDone;
  logic redirValidNxt, flushNxt, misalignNxt;
  logic redirValidQ, flushQ, misalignQ;
  pc_t  redirPcQ, misalignPcQ;

  assign brTaken         = i_BrValid_1 & i_JumpBranch_1;
  assign takenAligned    = brTaken & ~isMisaligned(i_Target_32);
  assign takenMisaligned = brTaken &  isMisaligned(i_Target_32);
  assign handshake       = (state == REQ) & i_RedirReady_1;
  assign sqLoad          = handshake & HAS_SQUASH;

  redir_squash_counter u_squashCnt (
    .clk     (i_Clk_1),
    .rst     (i_Rst_1),
    .load    (sqLoad),
    .loadVal (SQ_LOAD),
    .done    (sqDone)
  );

  always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
    if (i_Rst_1) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Branch inputs outside IDLE belong to the wrong path and are ignored.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (takenAligned) stateNxt = REQ;
      end
      REQ: begin
        if (i_RedirReady_1) stateNxt = HAS_SQUASH ? SQUASH : IDLE;
      end
      SQUASH: begin
        if (sqDone) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state they describe.
  always_comb begin
    redirValidNxt = (stateNxt == REQ);
    flushNxt      = (stateNxt != IDLE);
    misalignNxt   = (state == IDLE) & takenMisaligned;
  end

  always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
    if (i_Rst_1) begin
      redirValidQ <= 1'b0;
      flushQ      <= 1'b0;
      misalignQ   <= 1'b0;
      redirPcQ    <= '0;
      misalignPcQ <= '0;
    end else begin
      redirValidQ <= redirValidNxt;
      flushQ      <= flushNxt;
      misalignQ   <= misalignNxt;
      if ((state == IDLE) && takenAligned)    redirPcQ    <= i_Target_32;
      if ((state == IDLE) && takenMisaligned) misalignPcQ <= i_Target_32;
    end
  end

  assign o_RedirValid_1  = redirValidQ;
  assign o_RedirPc_32    = redirPcQ;
  assign o_FlushIfId_1   = flushQ;
  assign o_FlushIdEx_1   = flushQ;
  assign o_Misalign_1    = misalignQ;
  assign o_MisalignPc_32 = misalignPcQ;

`ifdef BRANCH_STATS_EN
  logic [31:0] branchCnt, takenCnt;

  // Saturating counters: only branches resolved while IDLE are on the correct path.
  always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
    if (i_Rst_1) begin
      branchCnt <= '0;
      takenCnt  <= '0;
    end else if ((state == IDLE) && i_BrValid_1) begin
      if (branchCnt != '1) branchCnt <= branchCnt + 32'd1;
      if (i_JumpBranch_1 && (takenCnt != '1)) takenCnt <= takenCnt + 32'd1;
    end
  end

  assign o_BranchCnt_32 = branchCnt;
  assign o_TakenCnt_32  = takenCnt;
`else
  assign o_BranchCnt_32 = '0;
  assign o_TakenCnt_32  = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: one instance with SQUASH_CYCLES=1, one with SQUASH_CYCLES=0, shared stimulus.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        brValid;
  logic        jumpBranch;
  logic [31:0] target;
  logic        redirReady;

  logic        redirValid, flushIfId, flushIdEx, misalign;
  logic [31:0] redirPc, misalignPc, branchCnt, takenCnt;
  logic        redirValid0, flushIfId0, flushIdEx0, misalign0;
  logic [31:0] redirPc0, misalignPc0, branchCnt0, takenCnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.SQUASH_CYCLES(1)) dut (
    .i_Clk_1         (clk),
    .i_Rst_1         (rst),
    .i_BrValid_1     (brValid),
    .i_JumpBranch_1  (jumpBranch),
    .i_Target_32     (target),
    .i_RedirReady_1  (redirReady),
    .o_RedirValid_1  (redirValid),
    .o_RedirPc_32    (redirPc),
    .o_FlushIfId_1   (flushIfId),
    .o_FlushIdEx_1   (flushIdEx),
    .o_Misalign_1    (misalign),
    .o_MisalignPc_32 (misalignPc),
    .o_BranchCnt_32  (branchCnt),
    .o_TakenCnt_32   (takenCnt)
  );

  branch_redirect_ctrl #(.SQUASH_CYCLES(0)) dut0 (
    .i_Clk_1         (clk),
    .i_Rst_1         (rst),
    .i_BrValid_1     (brValid),
    .i_JumpBranch_1  (jumpBranch),
    .i_Target_32     (target),
    .i_RedirReady_1  (redirReady),
    .o_RedirValid_1  (redirValid0),
    .o_RedirPc_32    (redirPc0),
    .o_FlushIfId_1   (flushIfId0),
    .o_FlushIdEx_1   (flushIdEx0),
    .o_Misalign_1    (misalign0),
    .o_MisalignPc_32 (misalignPc0),
    .o_BranchCnt_32  (branchCnt0),
    .o_TakenCnt_32   (takenCnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic jb, input logic [31:0] t);
    brValid    = v;
    jumpBranch = jb;
    target     = t;
  endtask

  logic [31:0] expBr, expTk;
  logic        vTab [5];
  logic        jTab [5];
  logic [31:0] tTab [5];

  initial begin
`ifdef BRANCH_STATS_EN
    expBr = 32'd5;
    expTk = 32'd2;
`else
    expBr = 32'd0;
    expTk = 32'd0;
`endif
    vTab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    jTab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tTab = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0106, 32'h0000_0030, 32'h0000_0040};

    rst = 1'b1;
    redirReady = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    step();
    step();
    chk("reset_valid", {31'd0, redirValid}, 32'd0);
    chk("reset_pc", redirPc, 32'd0);
    chk("reset_flush", {30'd0, flushIfId, flushIdEx}, 32'd0);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    chk("reset_cnt", branchCnt | takenCnt, 32'd0);
    rst = 1'b0;
    step();

    // Taken branch with ready already high: 1 REQ cycle, 1 SQUASH cycle.
    redirReady = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0100);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("t1_req_valid", {31'd0, redirValid}, 32'd1);
    chk("t1_req_pc", redirPc, 32'h0000_0100);
    chk("t1_req_flush", {30'd0, flushIfId, flushIdEx}, 32'd3);
    step();
    chk("t1_sq_valid", {31'd0, redirValid}, 32'd0);
    chk("t1_sq_flush", {30'd0, flushIfId, flushIdEx}, 32'd3);
    step();
    chk("t1_idle_flush", {30'd0, flushIfId, flushIdEx}, 32'd0);
    chk("t1_idle_valid", {31'd0, redirValid}, 32'd0);

    // Ready low for 3 REQ cycles, wrong-path branch pulses in REQ.
    redirReady = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_2000);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", {31'd0, redirValid}, 32'd1);
      chk("t2_hold_pc", redirPc, 32'h0000_2000);
      redirReady = (i == 3);
      drive(i < 2, 1'b1, 32'h0000_3000);
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
    chk("t2_sq_valid", {31'd0, redirValid}, 32'd0);
    chk("t2_sq_flush", {30'd0, flushIfId, flushIdEx}, 32'd3);
    step();
    chk("t2_idle_flush", {30'd0, flushIfId, flushIdEx}, 32'd0);
    step();
    chk("t2_no_second_redir", {31'd0, redirValid}, 32'd0);
    chk("t2_pc_held", redirPc, 32'h0000_2000);

    // Misaligned taken target.
    drive(1'b1, 1'b1, 32'h0000_0102);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("t3_misalign_pulse", {31'd0, misalign}, 32'd1);
    chk("t3_misalign_pc", misalignPc, 32'h0000_0102);
    chk("t3_no_valid", {31'd0, redirValid}, 32'd0);
    chk("t3_no_flush", {30'd0, flushIfId, flushIdEx}, 32'd0);
    step();
    chk("t3_misalign_low", {31'd0, misalign}, 32'd0);
    chk("t3_misalign_pc_hold", misalignPc, 32'h0000_0102);
    chk("t3_no_valid_after", {31'd0, redirValid}, 32'd0);

    // Statistics: 5 branches in IDLE, 2 taken (one misaligned).
    rst = 1'b1;
    step();
    rst = 1'b0;
    redirReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vTab[i], jTab[i], tTab[i]);
      step();
    end
    chk("t4_branch_cnt", branchCnt, expBr);
    chk("t4_taken_cnt", takenCnt, expTk);
    chk("t4_req_valid", {31'd0, redirValid}, 32'd1);
    drive(1'b1, 1'b1, 32'h0000_0050);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("t4_branch_cnt_req_ignored", branchCnt, expBr);
    chk("t4_taken_cnt_req_ignored", takenCnt, expTk);

    // Asynchronous reset in the middle of REQ.
    redirReady = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_0500);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("t5_req_valid", {31'd0, redirValid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, redirValid}, 32'd0);
    chk("t5_rst_pc", redirPc, 32'd0);
    chk("t5_rst_flush", {30'd0, flushIfId, flushIdEx}, 32'd0);
    chk("t5_rst_misalign_pc", misalignPc, 32'd0);
    chk("t5_rst_cnt", branchCnt | takenCnt, 32'd0);
    #1;
    rst = 1'b0;
    step();
    chk("t5_idle_after_rst", {31'd0, redirValid}, 32'd0);
    redirReady = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0600);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("t5_new_valid", {31'd0, redirValid}, 32'd1);
    chk("t5_new_pc", redirPc, 32'h0000_0600);
    step();
    step();

    // SQUASH_CYCLES=0 instance: single flush cycle, back-to-back branch.
    drive(1'b1, 1'b1, 32'h0000_0700);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("t6_req_valid", {31'd0, redirValid0}, 32'd1);
    chk("t6_req_flush", {30'd0, flushIfId0, flushIdEx0}, 32'd3);
    step();
    chk("t6_flush_one_cycle", {30'd0, flushIfId0, flushIdEx0}, 32'd0);
    chk("t6_valid_low", {31'd0, redirValid0}, 32'd0);
    drive(1'b1, 1'b1, 32'h0000_0800);
    step();
    drive(1'b0, 1'b0, 32'h0);
    chk("t6_b2b_valid", {31'd0, redirValid0}, 32'd1);
    chk("t6_b2b_pc", redirPc0, 32'h0000_0800);
    chk("t6_sq1_ignored_in_squash", {31'd0, redirValid}, 32'd0);
    chk("t6_sq1_pc_kept", redirPc, 32'h0000_0700);
    step();
    chk("t6_idle", {31'd0, redirValid0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the taken/not-taken result of the EX-stage jump/branch decision into a PC redirect toward the fetch unit. It squashes wrong-path instructions in IF/ID and ID/EX until the fetch unit has accepted the new PC and its refill latency has elapsed. The block sits between the EX-stage branch comparator and the IF-stage PC logic. It also flags misaligned jump targets.

## Interface

Parameters:
- SQUASH_CYCLES, 1, number of cycles flushing continues after the redirect handshake (fetch refill latency), range 0..15

Ports:
- i_Clk_1  input  1  clock; all state changes on the rising edge
- i_Rst_1  input  1  reset, asynchronous, active-high
- i_BrValid_1  input  1  EX holds a resolved branch/jump this cycle
- i_JumpBranch_1  input  1  branch/jump taken, qualified by i_BrValid_1
- i_Target_32  input  32  taken target PC, qualified by i_BrValid_1
- i_RedirReady_1  input  1  fetch unit accepts the redirect
- o_RedirValid_1  output  1  redirect request to the fetch unit
- o_RedirPc_32  output  32  latched redirect target
- o_FlushIfId_1  output  1  squash the IF/ID register
- o_FlushIdEx_1  output  1  squash the ID/EX register
- o_Misalign_1  output  1  one-cycle pulse: a taken target had target[1:0] != 0
- o_MisalignPc_32  output  32  offending target; holds until the next misalign event
- o_BranchCnt_32  output  32  resolved-branch count (see Configuration)
- o_TakenCnt_32  output  32  taken-branch count (see Configuration)

## Operation

- FSM has three states: IDLE, REQ and SQUASH. Reset state is IDLE.
- IDLE:
  - Outputs are low.
  - On i_BrValid_1 & i_JumpBranch_1 & target[1:0]==0: latch i_Target_32 into o_RedirPc_32 and enter REQ.
  - On i_BrValid_1 & i_JumpBranch_1 & target[1:0]!=0: pulse o_Misalign_1 the next cycle and load o_MisalignPc_32. There is no redirect and the state stays IDLE.
  - Not-taken branches cause no action.
- REQ:
  - o_RedirValid_1, o_FlushIfId_1 and o_FlushIdEx_1 are all high.
  - o_RedirPc_32 is stable.
  - i_BrValid_1 is ignored, because it is wrong-path.
  - On i_RedirReady_1: handshake completes. If SQUASH_CYCLES==0, go to IDLE. Otherwise load the counter with SQUASH_CYCLES and go to SQUASH.
- SQUASH:
  - o_RedirValid_1 is low. Both flushes are high.
  - i_BrValid_1 is ignored.
  - The counter decrements each cycle. When it reaches 1, go to IDLE at the next edge.
- Valid/ready rules:
  - o_RedirValid_1 never drops and o_RedirPc_32 never changes until ready is seen.
  - i_RedirReady_1 outside REQ has no effect.
- Reset, including mid-REQ or mid-SQUASH: immediately returns to IDLE. All outputs and counters clear to 0. The pending redirect is discarded.

## Timing

- All outputs are registered. The branch taken at cycle N gives o_RedirValid_1=1 at N+1.
- Ready at cycle M: o_RedirValid_1 is low at M+1.
- Flushes are high from N+1 through M+SQUASH_CYCLES inclusive.
- Minimum redirect occupancy, with ready already high: 1 + SQUASH_CYCLES cycles.
- A new taken branch is accepted in the first IDLE cycle after SQUASH ends.
- Misalign: o_Misalign_1 is high exactly at N+1.
- o_RedirPc_32 resets to 0 and holds its last value in IDLE.

## Configuration

- BRANCH_STATS_EN defined:
  - o_BranchCnt_32 increments on every i_BrValid_1 sampled in IDLE.
  - o_TakenCnt_32 increments on each such branch with i_JumpBranch_1=1, including misaligned ones.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- BRANCH_STATS_EN undefined: both outputs are tied to 0, and no counter flops are inferred.

## Structure

- Shared package branch_ctrl_pkg holds:
  - the FSM state encoding (IDLE=2'd0, REQ=2'd1, SQUASH=2'd2)
  - the PC width constant (32)
  - the squash counter width (4)
- One sub-module is natural: redir_squash_counter. It is a loadable down-counter with load/value inputs and a done output at count==1.
- The top level holds the FSM, the target/misalign registers and the optional stats.

## Test plan

- Taken branch, target 32'h0000_0100, ready held high, SQUASH_CYCLES=1:
  - o_RedirValid_1 is high for 1 cycle with o_RedirPc_32=32'h100.
  - Flushes are high for 2 cycles, then the FSM is in IDLE.
- Taken branch, target 32'h0000_2000, ready low for 3 cycles then high:
  - Valid is held 4 cycles and the PC is stable throughout.
  - i_BrValid_1 pulses during REQ cause no second redirect.
- Taken target 32'h0000_0102:
  - o_Misalign_1 pulses 1 cycle and o_MisalignPc_32=32'h102.
  - There is no o_RedirValid_1 and no flush.
- 5 branches, 2 taken, with BRANCH_STATS_EN defined:
  - o_BranchCnt_32=5 and o_TakenCnt_32=2.
  - Without the macro, both read 0.
- i_Rst_1 asserted mid-REQ (between edges):
  - All outputs are 0 immediately.
  - After release, a new taken branch is redirected normally.
- SQUASH_CYCLES=0:
  - Ready in the first REQ cycle gives flushes for exactly 1 cycle.
  - A back-to-back taken branch two cycles later is accepted.
